// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module : bcd_pkg
//  Shared BCD constants, digit type and serial-adder FSM state encoding.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_ADJ = 4'd6;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : bcd_pkg

`default_nettype wire

// File: rtl/bcd_digit_add.sv
// ============================================================================
//  Module : bcd_digit_add
//  Combinational single-digit BCD adder with decimal carry in/out.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_add
   import bcd_pkg::*;
(
   input  bcd_digit_t a,
   input  bcd_digit_t b,
   input  logic       ci,
   output bcd_digit_t s,
   output logic       co
);

   logic [4:0] w_sum;

   assign w_sum = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

   // Adding 6 modulo 16 folds binary 10..19 (and non-BCD input) back to one digit.
   always_comb begin
      s  = w_sum[3:0];
      co = 1'b0;
      if (w_sum > {1'b0, BCD_MAX}) begin
         s  = w_sum[3:0] + BCD_ADJ;
         co = 1'b1;
      end
   end

endmodule : bcd_digit_add

`default_nettype wire

// File: rtl/bcd_serial_adder.sv
// ============================================================================
//  Module : bcd_serial_adder
//  Digit-serial packed-BCD adder, LSD first, valid/ready on both sides.
//  Optional operand digit check enabled by macro BCD_SERIAL_CHECK_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_serial_adder
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4*DIGITS-1:0] in_a,
   input  logic [4*DIGITS-1:0] in_b,
   input  logic                in_cin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] out_sum,
   output logic                out_cout,
   output logic                out_err
);

   localparam int               W        = 4 * DIGITS;
   localparam int               CNT_W    = $clog2(DIGITS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             carry_q, carry_d;

   bcd_digit_t       w_digit;
   logic             w_co;

   bcd_digit_add u_digit_add (
      .a  (a_q[3:0]),
      .b  (b_q[3:0]),
      .ci (carry_q),
      .s  (w_digit),
      .co (w_co)
   );

`ifdef BCD_SERIAL_CHECK_EN
   logic err_q, err_d;
   logic w_bad;

   assign w_bad = (a_q[3:0] > BCD_MAX) || (b_q[3:0] > BCD_MAX);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
`ifdef BCD_SERIAL_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
`ifdef BCD_SERIAL_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
`ifdef BCD_SERIAL_CHECK_EN
      err_d     = err_q;
`endif
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = RUN;
               a_d     = in_a;
               b_d     = in_b;
               carry_d = in_cin;
               cnt_d   = '0;
`ifdef BCD_SERIAL_CHECK_EN
               err_d   = 1'b0;
`endif
            end
         end
         RUN: begin
            // New digit enters at the top so digit 0 lands at [3:0] after the last shift.
            sum_d   = {w_digit, sum_q[W-1:4]};
            a_d     = {4'b0000, a_q[W-1:4]};
            b_d     = {4'b0000, b_q[W-1:4]};
            carry_d = w_co;
            cnt_d   = cnt_q + 1'b1;
`ifdef BCD_SERIAL_CHECK_EN
            err_d   = err_q | w_bad;
`endif
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Result outputs are masked outside DONE so no partial sum is ever visible.
   assign out_sum  = out_valid ? sum_q : '0;
   assign out_cout = out_valid & carry_q;
`ifdef BCD_SERIAL_CHECK_EN
   assign out_err  = out_valid & err_q;
`else
   assign out_err  = 1'b0;
`endif

endmodule : bcd_serial_adder

`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
// ============================================================================
//  Module : tb_bcd_serial_adder
//  Self-checking bench for bcd_serial_adder (DIGITS=4), decimal reference model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_adder;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_err;

   int n_checks;
   int n_fail;

   bcd_serial_adder #(.DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned from_bcd(input logic [W-1:0] v);
      int unsigned r = 0;
      for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int unsigned v);
      logic [W-1:0] r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int unsigned pow10(input int n);
      int unsigned r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   // Decimal reference: {cout, sum} for BCD-valid operands.
   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
      int unsigned t;
      t = from_bcd(a) + from_bcd(b) + (cin ? 1 : 0);
      return {t >= pow10(DIGITS), to_bcd(t % pow10(DIGITS))};
   endfunction

   // Per-digit rule for operands that may contain non-BCD digits.
   function automatic logic [W:0] ref_digitwise(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic cin);
      logic [W-1:0] r = '0;
      int           c = cin ? 1 : 0;
      int           s;
      for (int i = 0; i < DIGITS; i++) begin
         s = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
         if (s > 9) begin
            r[4*i +: 4] = 4'((s + 6) % 16);
            c = 1;
         end else begin
            r[4*i +: 4] = 4'(s);
            c = 0;
         end
      end
      return {c[0], r};
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] r;
      for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
      return r;
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W:0] exp, input logic exp_err, input int hold);
      int           cyc;
      logic [W-1:0] held_sum;
      check("in_ready_idle", 32'(in_ready), 32'd1);
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_cin    = 1'($urandom);
      out_ready = 1'b1;
      cyc = 0;
      do begin
         check("in_ready_busy", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
         cyc++;
      end while (!out_valid && cyc < 3 * DIGITS);
      out_ready = 1'b0;
      check("latency", 32'(cyc), 32'(DIGITS));
      check("sum", 32'(out_sum), 32'(exp[W-1:0]));
      check("cout", 32'(out_cout), 32'(exp[W]));
      check("err", 32'(out_err), 32'(exp_err));
      held_sum = out_sum;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_sum", 32'(out_sum), 32'(held_sum));
         check("hold_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("release_valid", 32'(out_valid), 32'd0);
      check("release_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_sum"}, 32'(out_sum), 32'd0);
      check({tag, "_out_cout"}, 32'(out_cout), 32'd0);
      check({tag, "_out_err"}, 32'(out_err), 32'd0);
   endtask

`ifdef BCD_SERIAL_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   initial begin
      logic [W-1:0] a, b;
      logic         c;
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op(16'h0999, 16'h0001, 1'b0, {1'b0, 16'h1000}, 1'b0, 0);
      run_op(16'h9999, 16'h0001, 1'b0, {1'b1, 16'h0000}, 1'b0, 0);
      run_op(16'h1234, 16'h4321, 1'b1, {1'b0, 16'h5556}, 1'b0, 1);
      run_op(16'h9999, 16'h9999, 1'b1, {1'b1, 16'h9999}, 1'b0, 10);

      // Abort in RUN after two digit edges.
      in_a     = 16'h1111;
      in_b     = 16'h2222;
      in_cin   = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      @(posedge clk);
      #1;
      check_reset_outputs("abort_held");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op(16'h0005, 16'h0005, 1'b0, {1'b0, 16'h0010}, 1'b0, 0);

      // Non-BCD digit: sum follows the digit rule; out_err only with the check built in.
      run_op(16'h00A0, 16'h0001, 1'b0, ref_digitwise(16'h00A0, 16'h0001, 1'b0), CHK, 0);
      run_op(16'h0001, 16'h0001, 1'b0, {1'b0, 16'h0002}, 1'b0, 0);

      for (int n = 0; n < 20; n++) begin
         a = rand_bcd();
         b = rand_bcd();
         c = 1'($urandom);
         run_op(a, b, c, ref_add(a, b, c), 1'b0, int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_bcd_serial_adder

`default_nettype wire
